// File: rtl/uart_pkg.sv
// Shared UART types and constants: TX scheduler FSM states and CR/LF bytes.
// UART_TX_CRLF_EN adds the SEND_CR state used for LF -> CR,LF expansion.
package uart_pkg;

  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;

`ifdef UART_TX_CRLF_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_SEND_CR = 2'd2
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the TX scheduler: wrapping pointers with an extra lap bit,
// full/empty/count flags, and a synchronous flush that beats push and pop.
module uart_tx_fifo #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [DWIDTH-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              push_en;
  logic              pop_en;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    push_en  = i_push && !o_full && !i_flush;
    pop_en   = i_pop && !o_empty && !i_flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers core bytes and hands them to uart_ssh with a valid/ready handshake.
// Define UART_TX_CRLF_EN to expand each LF into CR,LF on the UART side.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DWIDTH-1:0]           i_core_data,
  input  logic                        i_core_valid,
  output logic                        o_core_ready,
  output logic [DWIDTH-1:0]           o_uart_data,
  output logic                        o_uart_valid,
  input  logic                        i_uart_ready,
  input  logic                        i_flush,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_busy
);

  tx_state_e         state_q, state_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              pop;
  logic              handshake;
  logic [DWIDTH-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  uart_tx_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_core_valid),
    .i_data  (i_core_data),
    .i_pop   (pop),
    .i_flush (i_flush),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_count)
  );

  assign handshake    = valid_q && i_uart_ready;
  assign o_core_ready = !fifo_full;
  assign o_uart_data  = data_q;
  assign o_uart_valid = valid_q;
  assign o_busy       = valid_q || (o_count != '0);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE, ST_SEND: begin
        // IDLE loads whenever data is waiting; SEND only after the current byte is taken.
        if (state_q == ST_IDLE || handshake) begin
          if (!fifo_empty && !i_flush) begin
            pop     = 1'b1;
            valid_d = 1'b1;
            data_d  = fifo_head;
            state_d = ST_SEND;
`ifdef UART_TX_CRLF_EN
            if (fifo_head == DWIDTH'(LF_BYTE)) begin
              data_d  = DWIDTH'(CR_BYTE);
              state_d = ST_SEND_CR;
            end
`endif
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
`ifdef UART_TX_CRLF_EN
      ST_SEND_CR: begin
        if (handshake) begin
          data_d  = DWIDTH'(LF_BYTE);
          state_d = ST_SEND;
        end
      end
`endif
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (DWIDTH=8, FIFO_DEPTH=16).
// Expectations follow UART_TX_CRLF_EN when the bench is built with it.
module tb_uart_tx_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_core_data;
  logic       i_core_valid;
  logic       o_core_ready;
  logic [7:0] o_uart_data;
  logic       o_uart_valid;
  logic       i_uart_ready;
  logic       i_flush;
  logic [4:0] o_count;
  logic       o_busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_q [$];

  uart_tx_scheduler #(
    .DWIDTH     (8),
    .FIFO_DEPTH (16)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_core_data  (i_core_data),
    .i_core_valid (i_core_valid),
    .o_core_ready (o_core_ready),
    .o_uart_data  (o_uart_data),
    .o_uart_valid (o_uart_valid),
    .i_uart_ready (i_uart_ready),
    .i_flush      (i_flush),
    .o_count      (o_count),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Inputs only change at posedge+1, so a handshake visible here happens at the next posedge.
  always @(negedge i_clk) begin
    if (i_rst_n && o_uart_valid && i_uart_ready) rx_q.push_back(o_uart_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n;
    i_core_valid = 1'b0;
    i_uart_ready = 1'b1;
    for (n = 0; n < 200; n++) begin
      tick();
      if (!o_busy) break;
    end
    if (n == 200) check_eq("drain_timeout", 32'd1, 32'd0);
    i_uart_ready = 1'b0;
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_core_data  = '0;
    i_core_valid = 1'b0;
    i_uart_ready = 1'b0;
    i_flush      = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", o_uart_valid, 1'b0);
    check_eq("rst_data",  o_uart_data, 8'h00);
    check_eq("rst_busy",  o_busy, 1'b0);
    check_eq("rst_ready", o_core_ready, 1'b1);
    check_eq("rst_count", o_count, 5'd0);
    i_rst_n = 1'b1;
    tick();

    // Single byte: valid appears one edge after the accepting edge, then idles.
    i_uart_ready = 1'b1;
    i_core_valid = 1'b1;
    i_core_data  = 8'h41;
    tick();
    i_core_valid = 1'b0;
    check_eq("one_valid_k", o_uart_valid, 1'b0);
    check_eq("one_count_k", o_count, 5'd1);
    tick();
    check_eq("one_valid_k1", o_uart_valid, 1'b1);
    check_eq("one_data_k1",  o_uart_data, 8'h41);
    check_eq("one_count_k1", o_count, 5'd0);
    tick();
    check_eq("one_valid_done", o_uart_valid, 1'b0);
    check_eq("one_busy_done",  o_busy, 1'b0);
    exp_q.push_back(8'h41);
    check_rx("one");

    // Fill with the UART stalled: byte 0 sits in the output register, 16 more fill the FIFO.
    i_uart_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      i_core_valid = 1'b1;
      i_core_data  = 8'h10 + 8'(i);
      exp_q.push_back(8'h10 + 8'(i));
      tick();
    end
    check_eq("full_count", o_count, 5'd16);
    check_eq("full_ready", o_core_ready, 1'b0);
    check_eq("full_head",  o_uart_data, 8'h10);
    i_core_data = 8'hEE;
    tick();
    tick();
    check_eq("full_ignore_count", o_count, 5'd16);
    drain();
    check_rx("full");

    // Streaming: push every edge with UART always ready.
    i_uart_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_core_valid = 1'b1;
      i_core_data  = 8'h30 + 8'(i);
      exp_q.push_back(8'h30 + 8'(i));
      tick();
      if (i >= 1) begin
        check_eq($sformatf("stream_count%0d", i), o_count, 5'd1);
        check_eq($sformatf("stream_valid%0d", i), o_uart_valid, 1'b1);
      end
    end
    drain();
    check_rx("stream");

    // LF handling.
    i_uart_ready = 1'b1;
    i_core_valid = 1'b1;
    i_core_data  = 8'h48;
    tick();
    i_core_data  = 8'h0A;
    tick();
    exp_q.push_back(8'h48);
`ifdef UART_TX_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
    drain();
    check_rx("crlf");

    // Flush with one byte presented and five buffered; a same-edge push is dropped.
    i_uart_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_core_valid = 1'b1;
      i_core_data  = 8'h51 + 8'(i);
      tick();
    end
    i_core_valid = 1'b0;
    tick();
    check_eq("flush_pre_count", o_count, 5'd5);
    check_eq("flush_pre_valid", o_uart_valid, 1'b1);
    i_flush      = 1'b1;
    i_core_valid = 1'b1;
    i_core_data  = 8'h99;
    tick();
    i_flush      = 1'b0;
    i_core_valid = 1'b0;
    check_eq("flush_count", o_count, 5'd0);
    check_eq("flush_valid", o_uart_valid, 1'b1);
    check_eq("flush_data",  o_uart_data, 8'h51);
    exp_q.push_back(8'h51);
    drain();
    check_rx("flush");

    // Asynchronous reset mid-SEND, then a clean byte afterwards.
    i_uart_ready = 1'b0;
    i_core_valid = 1'b1;
    i_core_data  = 8'h61;
    tick();
    i_core_valid = 1'b0;
    tick();
    check_eq("arst_pre_valid", o_uart_valid, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("arst_valid", o_uart_valid, 1'b0);
    check_eq("arst_count", o_count, 5'd0);
    check_eq("arst_ready", o_core_ready, 1'b1);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    i_uart_ready = 1'b1;
    i_core_valid = 1'b1;
    i_core_data  = 8'h62;
    tick();
    exp_q.push_back(8'h62);
    drain();
    check_rx("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
